// File: rtl/video_ts_pkg.sv
// Shared definitions for the TS video subsystem: grant-owner encoding and
// the default burst length of the TS DRAM arbiter.
package video_ts_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_TM   = 2'b01,
        OWN_TSR  = 2'b10
    } owner_e;

    localparam int unsigned BURST_DEFAULT = 8;

endpackage

// File: rtl/video_ts_arb.sv
// Two-requester arbiter sharing the TS DRAM read port between the tilemap
// prefetch and the renderer, with a bounded number of words per grant.
module video_ts_arb
    import video_ts_pkg::*;
#(
    parameter int unsigned BURST = BURST_DEFAULT,
    parameter int unsigned AW    = 21
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          tm_req,
    input  logic [AW-1:0] tm_addr,
    output logic          tm_next,
    input  logic          tsr_req,
    input  logic [AW-1:0] tsr_addr,
    output logic          tsr_next,
    output logic          dram_req,
    output logic [AW-1:0] dram_addr,
    input  logic          dram_next,
    output logic [1:0]    owner
);

    localparam int unsigned CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

    owner_e        owner_q, owner_d;
    owner_e        last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          own_req;

    // Both requesting: whoever was not served last wins.
    function automatic owner_e pick(input logic tm, input logic tsr, input owner_e lst);
        owner_e res;
        res = OWN_NONE;
        if (tm && tsr) begin
            res = (lst == OWN_TM) ? OWN_TSR : OWN_TM;
        end else if (tm) begin
            res = OWN_TM;
        end else if (tsr) begin
            res = OWN_TSR;
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_NONE;
            last_q  <= OWN_TSR;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        own_req = 1'b0;
        case (owner_q)
            OWN_TM:  own_req = tm_req;
            OWN_TSR: own_req = tsr_req;
            default: own_req = 1'b0;
        endcase

        if (start) begin
            owner_d = OWN_NONE;
            last_d  = OWN_TSR;
            cnt_d   = '0;
        end else if (owner_q == OWN_NONE) begin
            owner_d = pick(tm_req, tsr_req, last_q);
            cnt_d   = '0;
        end else if (!own_req || (dram_next && cnt_q == CNT_LAST)) begin
            // Current owner counts as last so the other side wins if requesting.
            owner_d = pick(tm_req, tsr_req, owner_q);
            last_d  = owner_q;
            cnt_d   = '0;
        end else if (dram_next) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        dram_req  = 1'b0;
        dram_addr = '0;
        case (owner_q)
            OWN_TM: begin
                dram_req  = tm_req;
                dram_addr = tm_addr;
            end
            OWN_TSR: begin
                dram_req  = tsr_req;
                dram_addr = tsr_addr;
            end
            default: begin
                dram_req  = 1'b0;
                dram_addr = '0;
            end
        endcase
    end

    assign tm_next  = dram_next && (owner_q == OWN_TM);
    assign tsr_next = dram_next && (owner_q == OWN_TSR);
    assign owner    = owner_q;

endmodule

// File: tb/tb_video_ts_arb.sv
// Self-checking bench for video_ts_arb: directed scenarios plus randomized
// traffic compared against a words-per-grant reference model.
module tb_video_ts_arb;

    localparam int BURST = 8;
    localparam int AW    = 21;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          tm_req;
    logic [AW-1:0] tm_addr;
    logic          tm_next;
    logic          tsr_req;
    logic [AW-1:0] tsr_addr;
    logic          tsr_next;
    logic          dram_req;
    logic [AW-1:0] dram_addr;
    logic          dram_next;
    logic [1:0]    owner;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference model: 0 none, 1 TM, 2 TSR; words = words served in current grant.
    int m_owner = 0;
    int m_words = 0;
    int m_last  = 2;

    always #5 clk = ~clk;

    video_ts_arb #(.BURST(BURST), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .tm_req   (tm_req),
        .tm_addr  (tm_addr),
        .tm_next  (tm_next),
        .tsr_req  (tsr_req),
        .tsr_addr (tsr_addr),
        .tsr_next (tsr_next),
        .dram_req (dram_req),
        .dram_addr(dram_addr),
        .dram_next(dram_next),
        .owner    (owner)
    );

    function automatic int pick_m(input bit a, input bit b, input int lst);
        if (a && b) return (lst == 1) ? 2 : 1;
        if (a) return 1;
        if (b) return 2;
        return 0;
    endfunction

    // Inputs change mid-low-phase; outputs are sampled 1 time unit later.
    task automatic drive(input bit s, input bit a, input bit b, input bit dn);
        @(negedge clk);
        start     = s;
        tm_req    = a;
        tsr_req   = b;
        dram_next = dn;
        tm_addr   = AW'($urandom);
        tsr_addr  = AW'($urandom);
        #1;
    endtask

    // Advance model and DUT across one rising edge.
    task automatic tick();
        int no, nw, nl;
        bit rq;
        no = m_owner; nw = m_words; nl = m_last;
        if (!rst_n || start) begin
            no = 0; nw = 0; nl = 2;
        end else if (m_owner == 0) begin
            no = pick_m(tm_req, tsr_req, m_last);
            nw = 0;
        end else begin
            rq = (m_owner == 1) ? tm_req : tsr_req;
            nw = m_words + (dram_next ? 1 : 0);
            if (!rq || nw == BURST) begin
                nl = m_owner;
                no = pick_m(tm_req, tsr_req, m_owner);
                nw = 0;
            end
        end
        @(posedge clk);
        m_owner = no; m_words = nw; m_last = nl;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 1, 1, 1);
        cmp_cnt++;
        if ({owner, dram_req, dram_addr, tm_next, tsr_next} !== '0) begin
            err_cnt++;
            $display("FAIL reset_hold: owner=%b req=%b addr=%h tmn=%b tsrn=%b required all zero",
                     owner, dram_req, dram_addr, tm_next, tsr_next);
        end
        tick();
        drive(0, 1, 1, 0);
        rst_n = 1'b1;
        cmp_cnt++;
        if (owner !== 2'b00) begin
            err_cnt++;
            $display("FAIL reset_release_idle: owner=%b required 00", owner);
        end
        tick();
        drive(0, 1, 1, 0);
        cmp_cnt++;
        if (owner !== 2'b01 || dram_req !== 1'b1 || dram_addr !== tm_addr) begin
            err_cnt++;
            $display("FAIL reset_first_grant: owner=%b req=%b addr=%h required 01/1/%h",
                     owner, dram_req, dram_addr, tm_addr);
        end
        tick();
    endtask

    task automatic test_fairness();
        bit exp_tm;
        drive(1, 1, 1, 0); tick();
        drive(0, 1, 1, 0); tick();
        for (int i = 0; i < 4 * BURST; i++) begin
            drive(0, 1, 1, 1);
            exp_tm = ((i / BURST) % 2) == 0;
            cmp_cnt++;
            if (tm_next !== exp_tm || tsr_next !== !exp_tm) begin
                err_cnt++;
                $display("FAIL fairness[%0d]: tm_next=%b tsr_next=%b required %b/%b",
                         i, tm_next, tsr_next, exp_tm, !exp_tm);
            end
            tick();
        end
    endtask

    task automatic test_solo();
        int n;
        n = 0;
        drive(1, 0, 1, 0); tick();
        drive(0, 0, 1, 0); tick();
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1, 1);
            if (tsr_next === 1'b1) n++;
            cmp_cnt++;
            if (owner !== 2'b10 || tm_next !== 1'b0 || tsr_next !== 1'b1) begin
                err_cnt++;
                $display("FAIL solo[%0d]: owner=%b tmn=%b tsrn=%b required 10/0/1",
                         i, owner, tm_next, tsr_next);
            end
            tick();
        end
        cmp_cnt++;
        if (n != 20) begin
            err_cnt++;
            $display("FAIL solo_count: tsr_next pulses=%0d required 20", n);
        end
    endtask

    task automatic test_drop();
        drive(1, 1, 1, 0); tick();
        drive(0, 1, 1, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 1);
            cmp_cnt++;
            if (tm_next !== 1'b1) begin
                err_cnt++;
                $display("FAIL drop_tm_word[%0d]: tm_next=%b required 1", i, tm_next);
            end
            tick();
        end
        drive(0, 0, 1, 0);
        cmp_cnt++;
        if (owner !== 2'b01 || dram_req !== 1'b0) begin
            err_cnt++;
            $display("FAIL drop_cycle: owner=%b req=%b required 01/0", owner, dram_req);
        end
        tick();
        for (int i = 0; i < BURST; i++) begin
            drive(0, 1, 1, 1);
            cmp_cnt++;
            if (owner !== 2'b10 || dram_addr !== tsr_addr || tsr_next !== 1'b1) begin
                err_cnt++;
                $display("FAIL drop_tsr[%0d]: owner=%b addr=%h tsrn=%b required 10/%h/1",
                         i, owner, dram_addr, tsr_next, tsr_addr);
            end
            tick();
        end
        drive(0, 1, 1, 0);
        cmp_cnt++;
        if (owner !== 2'b01) begin
            err_cnt++;
            $display("FAIL drop_cnt_restart: owner=%b required 01", owner);
        end
        tick();
    endtask

    task automatic test_line_start();
        drive(1, 0, 1, 0); tick();
        drive(0, 0, 1, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 1); tick();
        end
        drive(1, 1, 1, 1);
        cmp_cnt++;
        if (tsr_next !== 1'b1 || tm_next !== 1'b0) begin
            err_cnt++;
            $display("FAIL start_fwd: tsrn=%b tmn=%b required 1/0", tsr_next, tm_next);
        end
        tick();
        drive(0, 1, 1, 0);
        cmp_cnt++;
        if (owner !== 2'b00 || dram_req !== 1'b0) begin
            err_cnt++;
            $display("FAIL start_idle: owner=%b req=%b required 00/0", owner, dram_req);
        end
        tick();
        drive(0, 1, 1, 0);
        cmp_cnt++;
        if (owner !== 2'b01) begin
            err_cnt++;
            $display("FAIL start_tm_first: owner=%b required 01", owner);
        end
        tick();
    endtask

    task automatic test_idle_ack();
        drive(1, 0, 0, 0); tick();
        drive(0, 0, 0, 1);
        cmp_cnt++;
        if (tm_next !== 1'b0 || tsr_next !== 1'b0 || owner !== 2'b00 || dram_addr !== '0) begin
            err_cnt++;
            $display("FAIL idle_ack: tmn=%b tsrn=%b owner=%b addr=%h required 0/0/00/0",
                     tm_next, tsr_next, owner, dram_addr);
        end
        tick();
        drive(0, 0, 0, 0);
        cmp_cnt++;
        if (owner !== 2'b00) begin
            err_cnt++;
            $display("FAIL idle_ack_state: owner=%b required 00", owner);
        end
        tick();
    endtask

    task automatic test_random();
        logic [AW+4:0] act, exp;
        bit er;
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
            er = (m_owner == 1) ? tm_req : (m_owner == 2) ? tsr_req : 1'b0;
            exp = {2'(m_owner), er,
                   (m_owner == 1) ? tm_addr : (m_owner == 2) ? tsr_addr : '0,
                   dram_next && m_owner == 1, dram_next && m_owner == 2};
            act = {owner, dram_req, dram_addr, tm_next, tsr_next};
            cmp_cnt++;
            if (act !== exp) begin
                err_cnt++;
                $display("FAIL random[%0d]: {owner,req,addr,tmn,tsrn}=%h required %h", i, act, exp);
            end
            tick();
        end
    endtask

    initial begin
        start = 0; tm_req = 0; tsr_req = 0; dram_next = 0;
        tm_addr = '0; tsr_addr = '0; rst_n = 0;
        test_reset();
        test_fairness();
        test_solo();
        test_drop();
        test_line_start();
        test_idle_ack();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
